quadrature_step_gen: RTL and testbench
======================================

Name: quadrature_step_gen

Overview:
- Decodes a 2-channel quadrature encoder (A/B, asynchronous board pins) into a one-clock step-enable pulse plus a direction level.
- Its outputs form the enable/up-down control pair that drives the team's modulo up/down counter.
- Also keeps its own modulo position count with a wrap pulse, so it can connect directly to a Nios II PIO.
- Adds input synchronisation, glitch filtering and illegal-transition detection.

Parameters:
- FILTER_LEN, 4: consecutive clocks a synchronised channel must hold a new value before it is accepted (legal range 1..255).
- POS_MAX, 24: positions per revolution; oPOSITION counts 0..POS_MAX-1 (legal minimum 2).
- WIDTH, ceil(log2(POS_MAX)) = 5: width of oPOSITION.

Ports:
- iCLOCK  in  1  system clock; every flop is on its rising edge.
- iRESET  in  1  reset. Asynchronous and active-high, single clock domain.
- iA  in  1  encoder channel A, asynchronous.
- iB  in  1  encoder channel B, asynchronous.
- iENABLE  in  1  when 0, decoding continues but no steps, position changes or wraps are produced.
- iZERO  in  1  synchronous clear of oPOSITION.
- iCLEAR_ERR  in  1  synchronous clear of oERROR.
- oSTEP  out  1  one-clock pulse per accepted quarter-step.
- oUP_DOWN  out  1  direction of the last accepted step: 1 = up, 0 = down.
- oPOSITION  out  WIDTH  modulo position.
- oTC  out  1  one-clock pulse when oPOSITION wraps.
- oERROR  out  1  sticky illegal-transition flag.

Behaviour:
- Reset values:
  - oSTEP=0, oUP_DOWN=1, oPOSITION=0, oTC=0, oERROR=0.
  - Synchroniser flops and filtered A/B = 0; filter counters = 0.
  - FSM = INIT; settle counter = 0.
- Reset mid-operation: immediate, with the same values as above; any in-progress step is lost.
- Synchroniser: two flops per channel; no logic between the stages.
- Filter, per channel:
  - If the synchronised value equals the filtered value, the counter clears.
  - Otherwise the counter increments; on reaching FILTER_LEN the filtered value updates and the counter clears.
  - A pulse shorter than FILTER_LEN clocks never reaches the filtered value.
  - Latency from pin edge to filtered edge: 2+FILTER_LEN clocks.
- FSM states: INIT, S00, S01, S11, S10 (named for the filtered {A,B}).
- INIT:
  - Filtered values track the synchronised values directly.
  - Lasts FILTER_LEN+2 clocks, then enters the state matching filtered {A,B}.
  - No step and no error on exit.
- Forward sequence S00->S01->S11->S10->S00: one step, direction up.
- Reverse sequence: one step, direction down.
- No change in {A,B}: stay in the current state, no step.
- Both bits change in the same clock (e.g. S00->S11):
  - oERROR set to 1, no step.
  - FSM adopts the new state.
  - oUP_DOWN is unchanged.
- Step timing: a transition detected at clock n gives, at clock n+1, oSTEP=1 for exactly one cycle, oUP_DOWN = direction, and oPOSITION updated.
- oUP_DOWN holds its value between steps.
- Position updates, only when iENABLE=1:
  - Up: POS_MAX-1 -> 0 with oTC=1 for that cycle; otherwise +1.
  - Down: 0 -> POS_MAX-1 with oTC=1; otherwise -1.
- iENABLE=0:
  - Filter and FSM keep tracking.
  - oSTEP, oTC stay 0; oPOSITION holds; oUP_DOWN holds.
  - Re-enabling produces no spurious step.
- iZERO=1:
  - oPOSITION becomes 0 next cycle and oTC=0, even if a step coincides.
  - oSTEP and oUP_DOWN still reflect a coinciding step.
- oERROR:
  - Stays 1 until iCLEAR_ERR=1.
  - If iCLEAR_ERR and a new illegal transition occur in the same cycle, set wins.
- Arithmetic: all position compares and loads use WIDTH bits; POS_MAX-1 is truncated to WIDTH.

Test Plan:
- Reset, then A=B=0 for 20 clocks -> oPOSITION=0, oSTEP never 1, oERROR=0, oUP_DOWN=1.
- Forward sequence with 10 clocks per phase, 24 quarter-steps, FILTER_LEN=4 -> 24 oSTEP pulses with oUP_DOWN=1. oPOSITION goes 1..23 then 0; oTC=1 only on the 23->0 cycle. First pulse comes 7 clocks after the A edge.
- From oPOSITION=0, one reverse quarter-step (S00->S10) -> oSTEP=1, oUP_DOWN=0, oPOSITION=23, oTC=1.
- 3-clock glitch on A with FILTER_LEN=4 -> no oSTEP, FSM state unchanged, oERROR=0.
- A and B toggled in the same clock from S00 -> oERROR=1, no oSTEP, oPOSITION unchanged. Then iCLEAR_ERR pulse -> oERROR=0 next cycle.
- Simultaneous and mid-operation events:
  - iENABLE=0 over 4 forward steps -> oPOSITION unchanged, no oSTEP.
  - Then iENABLE=1 plus 1 step -> oPOSITION+1.
  - iZERO coinciding with a step at oPOSITION=23 -> oPOSITION=0, oTC=0, oSTEP=1.
  - iRESET asserted mid-sequence -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/quadrature_step_gen.sv
// ---------------------------------------------------------------------------
// quadrature_step_gen
//
// Decodes a two-channel quadrature encoder into a one-clock step pulse and a
// direction level. It also keeps a modulo position count that raises a wrap
// pulse, so it can drive an up/down counter or sit directly behind a PIO.
// Each pin passes through a two-flop synchroniser and then a glitch filter.
// The filtered {A,B} pair is then checked by a small FSM.
//
// Ports
//   iCLOCK      in   system clock, every flop is on its rising edge
//   iRESET      in   asynchronous active-high reset
//   iA, iB      in   raw encoder channels (asynchronous to iCLOCK)
//   iENABLE     in   0 = keep tracking the encoder, but produce no steps,
//                    no position change and no wrap
//   iZERO       in   synchronous clear of oPOSITION (takes priority over a step)
//   iCLEAR_ERR  in   synchronous clear of oERROR (a new error in the same
//                    cycle wins)
//   oSTEP       out  one-clock pulse per accepted quarter-step
//   oUP_DOWN    out  direction of the last accepted step (1 = up)
//   oPOSITION   out  modulo position 0..POS_MAX-1
//   oTC         out  one-clock pulse when oPOSITION wraps
//   oERROR      out  sticky flag for a transition that changes both channels
//   oSTATE      out  debug view of the FSM state:
//                    000 = INIT, 1ab = S<a><b>, e.g. 101 = S01
//
// Handshake: there is none. oSTEP is a single-cycle strobe. oUP_DOWN,
// oPOSITION and oTC are valid in the same cycle as oSTEP. The consumer
// samples them on the next rising edge of iCLOCK. The consumer cannot
// apply back-pressure.
// ---------------------------------------------------------------------------
module quadrature_step_gen #(
    parameter int FILTER_LEN = 4,
    parameter int POS_MAX    = 24,
    parameter int WIDTH      = $clog2(POS_MAX)
) (
    input  logic             iCLOCK,
    input  logic             iRESET,
    input  logic             iA,
    input  logic             iB,
    input  logic             iENABLE,
    input  logic             iZERO,
    input  logic             iCLEAR_ERR,
    output logic             oSTEP,
    output logic             oUP_DOWN,
    output logic [WIDTH-1:0] oPOSITION,
    output logic             oTC,
    output logic             oERROR,
    output logic [2:0]       oSTATE
);

    // The state encoding carries the filtered {A,B} value in its low bits.
    // This lets the next state be built straight from the channel values.
    typedef enum logic [2:0] {
        ST_INIT = 3'b000,
        ST_S00  = 3'b100,
        ST_S01  = 3'b101,
        ST_S10  = 3'b110,
        ST_S11  = 3'b111
    } state_t;

    localparam logic [7:0]       FILT_LAST   = 8'(FILTER_LEN - 1);
    localparam logic [8:0]       SETTLE_LAST = 9'(FILTER_LEN + 1);
    localparam logic [WIDTH-1:0] POS_TOP     = WIDTH'(POS_MAX - 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  sync1;        // {A,B} first synchroniser stage
    logic [1:0]  sync2;        // {A,B} second synchroniser stage
    logic [1:0]  filt;         // filtered {A,B}
    logic [7:0]  filt_cnt [2]; // index 1 = A, index 0 = B
    logic [8:0]  settle;
    logic [1:0]  prev_idx;
    logic [1:0]  new_idx;
    logic [1:0]  delta;
    logic        step_det;
    logic        dir_det;
    logic        err_det;

    // Position of a {A,B} code along the forward cycle 00,01,11,10.
    // This is the Gray-to-binary conversion of the code.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    // Synchroniser: plain two-flop chains with no logic between the stages.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {iA, iB};
            sync2 <= sync1;
        end
    end

    // Glitch filter. A channel must differ from its filtered value for
    // FILTER_LEN consecutive clocks before the filtered value is updated.
    // During INIT the filtered value follows the synchroniser directly.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            filt <= 2'b00;
            for (int i = 0; i < 2; i++) filt_cnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (state == ST_INIT) begin
                    filt[i]     <= sync2[i];
                    filt_cnt[i] <= 8'd0;
                end else if (sync2[i] == filt[i]) begin
                    filt_cnt[i] <= 8'd0;
                end else if (filt_cnt[i] == FILT_LAST) begin
                    filt[i]     <= sync2[i];
                    filt_cnt[i] <= 8'd0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 8'd1;
                end
            end
        end
    end

    // FSM state register and the INIT settle counter.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state  <= ST_INIT;
            settle <= 9'd0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) settle <= settle + 9'd1;
            else                  settle <= 9'd0;
        end
    end

    // Next state. When INIT exits, it uses the value that the filter loads
    // on that same edge. This keeps state and filt equal, so leaving INIT
    // never looks like a transition.
    always_comb begin
        state_next = state;
        if (state == ST_INIT) begin
            if (settle == SETTLE_LAST) state_next = state_t'({1'b1, sync2});
        end else begin
            state_next = state_t'({1'b1, filt});
        end
    end

    // Transition decode. One position forward is an up step, one position
    // back is a down step, and two positions means both channels changed.
    always_comb begin
        prev_idx = gray_idx(state[1:0]);
        new_idx  = gray_idx(filt);
        delta    = new_idx - prev_idx;
        step_det = 1'b0;
        dir_det  = 1'b0;
        err_det  = 1'b0;
        if (state != ST_INIT) begin
            case (delta)
                2'd1:    begin step_det = 1'b1; dir_det = 1'b1; end
                2'd3:    begin step_det = 1'b1; dir_det = 1'b0; end
                2'd2:    err_det = 1'b1;
                default: ;
            endcase
        end
    end

    // Registered outputs: each step appears one clock after it is detected.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            oSTEP     <= 1'b0;
            oUP_DOWN  <= 1'b1;
            oPOSITION <= '0;
            oTC       <= 1'b0;
            oERROR    <= 1'b0;
        end else begin
            oSTEP <= step_det & iENABLE;
            oTC   <= 1'b0;
            if (step_det && iENABLE) oUP_DOWN <= dir_det;

            if (iZERO) begin
                oPOSITION <= '0;
            end else if (step_det && iENABLE) begin
                if (dir_det) begin
                    if (oPOSITION == POS_TOP) begin
                        oPOSITION <= '0;
                        oTC       <= 1'b1;
                    end else begin
                        oPOSITION <= oPOSITION + WIDTH'(1);
                    end
                end else begin
                    if (oPOSITION == '0) begin
                        oPOSITION <= POS_TOP;
                        oTC       <= 1'b1;
                    end else begin
                        oPOSITION <= oPOSITION - WIDTH'(1);
                    end
                end
            end

            if (err_det)         oERROR <= 1'b1;
            else if (iCLEAR_ERR) oERROR <= 1'b0;
        end
    end

    assign oSTATE = state;

endmodule

// File: tb/tb_quadrature_step_gen.sv
// ---------------------------------------------------------------------------
// tb_quadrature_step_gen
//
// Self-checking bench for quadrature_step_gen (FILTER_LEN=4, POS_MAX=24).
// The reference model works at the encoder level. It looks up where each
// {A,B} code sits in the forward cycle. From that it works out whether a move
// is up, down, illegal or no change. The expected position comes from plain
// modulo arithmetic on an integer.
// ---------------------------------------------------------------------------
module tb_quadrature_step_gen;

    localparam int FL = 4;
    localparam int PM = 24;
    localparam int W  = 5;
    localparam int STEP_LAT = FL + 3; // pin edge -> oSTEP, in clocks

    // clock / reset / stimulus
    logic         clk = 1'b0;
    logic         rst;
    logic         a, b, en, zero, clr;
    logic         step, up_down, tc, err;
    logic [W-1:0] pos;
    logic [2:0]   st;

    always #5 clk = ~clk;

    quadrature_step_gen #(.FILTER_LEN(FL), .POS_MAX(PM), .WIDTH(W)) dut (
        .iCLOCK    (clk),
        .iRESET    (rst),
        .iA        (a),
        .iB        (b),
        .iENABLE   (en),
        .iZERO     (zero),
        .iCLEAR_ERR(clr),
        .oSTEP     (step),
        .oUP_DOWN  (up_down),
        .oPOSITION (pos),
        .oTC       (tc),
        .oERROR    (err),
        .oSTATE    (st)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model
    logic [1:0]   fwd_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int           m_pos;
    logic         m_dir;
    logic         m_err;
    logic         m_en;
    logic [1:0]   m_ab;
    int           e_kind;   // 0 none, 1 up, 2 down, 3 illegal
    logic         e_tc;
    logic [W-1:0] exp_q [$];

    // observations from drive_phase
    int           obs_steps;
    int           obs_first;
    int           obs_tc_cnt;
    logic         obs_dir;
    logic [W-1:0] obs_pos;

    function automatic int idx_of(input logic [1:0] ab);
        for (int i = 0; i < 4; i++) if (fwd_seq[i] == ab) return i;
        return 0;
    endfunction

    task automatic model_move(input logic [1:0] ab);
        int d;
        d = (idx_of(ab) - idx_of(m_ab) + 4) % 4;
        e_kind = 0;
        e_tc   = 1'b0;
        if (d == 2) begin
            e_kind = 3;
            m_err  = 1'b1;
        end else if (d == 1 || d == 3) begin
            e_kind = (d == 1) ? 1 : 2;
            if (m_en) begin
                m_dir = (d == 1);
                if (d == 1) begin
                    m_pos = (m_pos + 1) % PM;
                    e_tc  = (m_pos == 0);
                end else begin
                    m_pos = (m_pos + PM - 1) % PM;
                    e_tc  = (m_pos == PM - 1);
                end
            end
        end
        m_ab = ab;
    endtask

    function automatic int exp_steps();
        return ((e_kind == 1 || e_kind == 2) && m_en) ? 1 : 0;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply {A,B} to the pins and run `hold` clocks, recording what happens.
    task automatic drive_phase(input logic [1:0] ab, input int hold);
        a = ab[1];
        b = ab[0];
        obs_steps  = 0;
        obs_first  = -1;
        obs_tc_cnt = 0;
        for (int c = 1; c <= hold; c++) begin
            tick();
            if (step === 1'b1) begin
                obs_steps++;
                if (obs_first < 0) begin
                    obs_first = c;
                    obs_dir   = up_down;
                    obs_pos   = pos;
                end
            end
            if (tc === 1'b1) obs_tc_cnt++;
        end
    endtask

    // test tasks
    task automatic test_reset();
        int steps_seen;
        rst = 1'b1; a = 1'b0; b = 1'b0; en = 1'b1; zero = 1'b0; clr = 1'b0;
        repeat (3) tick();
        n_vec++; if (st !== 3'b000) begin n_err++; $display("FAIL reset_state: got %b expected 000", st); end
        rst = 1'b0;
        steps_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step === 1'b1) steps_seen++;
        end
        m_pos = 0; m_dir = 1'b1; m_err = 1'b0; m_en = 1'b1; m_ab = 2'b00;
        n_vec++; if (steps_seen != 0) begin n_err++; $display("FAIL reset_no_step: got %0d expected 0", steps_seen); end
        n_vec++; if (pos !== W'(0)) begin n_err++; $display("FAIL reset_pos: got %0d expected 0", pos); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err); end
        n_vec++; if (up_down !== 1'b1) begin n_err++; $display("FAIL reset_dir: got %b expected 1", up_down); end
        n_vec++; if (st !== 3'b100) begin n_err++; $display("FAIL reset_settle_state: got %b expected 100", st); end
    endtask

    task automatic test_forward();
        logic [1:0]   nab;
        logic [W-1:0] exp;
        for (int i = 0; i < 24; i++) begin
            nab = fwd_seq[(idx_of(m_ab) + 1) % 4];
            model_move(nab);
            exp_q.push_back(W'(m_pos));
            drive_phase(nab, 10);
            exp = exp_q.pop_front();
            n_vec++; if (obs_steps != 1) begin n_err++; $display("FAIL fwd_steps[%0d]: got %0d expected 1", i, obs_steps); end
            n_vec++; if (obs_first != STEP_LAT) begin n_err++; $display("FAIL fwd_latency[%0d]: got %0d expected %0d", i, obs_first, STEP_LAT); end
            n_vec++; if (obs_pos !== exp) begin n_err++; $display("FAIL fwd_pos[%0d]: got %0d expected %0d", i, obs_pos, exp); end
            n_vec++; if (obs_dir !== 1'b1) begin n_err++; $display("FAIL fwd_dir[%0d]: got %b expected 1", i, obs_dir); end
            n_vec++; if (obs_tc_cnt != int'(e_tc)) begin n_err++; $display("FAIL fwd_tc[%0d]: got %0d expected %0d", i, obs_tc_cnt, e_tc); end
        end
    endtask

    task automatic test_reverse_wrap();
        model_move(2'b10);
        drive_phase(2'b10, 10);
        n_vec++; if (obs_steps != 1) begin n_err++; $display("FAIL rev_steps: got %0d expected 1", obs_steps); end
        n_vec++; if (obs_dir !== 1'b0) begin n_err++; $display("FAIL rev_dir: got %b expected 0", obs_dir); end
        n_vec++; if (obs_pos !== W'(m_pos)) begin n_err++; $display("FAIL rev_pos: got %0d expected %0d", obs_pos, m_pos); end
        n_vec++; if (obs_tc_cnt != 1) begin n_err++; $display("FAIL rev_tc: got %0d expected 1", obs_tc_cnt); end
    endtask

    task automatic test_glitch();
        int total;
        drive_phase(m_ab ^ 2'b10, FL - 1);
        total = obs_steps;
        drive_phase(m_ab, 12);
        total += obs_steps;
        n_vec++; if (total != 0) begin n_err++; $display("FAIL glitch_steps: got %0d expected 0", total); end
        n_vec++; if (st !== {1'b1, m_ab}) begin n_err++; $display("FAIL glitch_state: got %b expected %b", st, {1'b1, m_ab}); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL glitch_err: got %b expected 0", err); end
        n_vec++; if (pos !== W'(m_pos)) begin n_err++; $display("FAIL glitch_pos: got %0d expected %0d", pos, m_pos); end
    endtask

    task automatic test_illegal();
        model_move(2'b00);
        drive_phase(2'b00, 10);
        n_vec++; if (pos !== W'(m_pos)) begin n_err++; $display("FAIL ill_pre_pos: got %0d expected %0d", pos, m_pos); end
        model_move(2'b11);
        drive_phase(2'b11, 10);
        n_vec++; if (obs_steps != 0) begin n_err++; $display("FAIL ill_steps: got %0d expected 0", obs_steps); end
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL ill_err: got %b expected 1", err); end
        n_vec++; if (pos !== W'(m_pos)) begin n_err++; $display("FAIL ill_pos: got %0d expected %0d", pos, m_pos); end
        n_vec++; if (up_down !== m_dir) begin n_err++; $display("FAIL ill_dir: got %b expected %b", up_down, m_dir); end
        n_vec++; if (st !== 3'b111) begin n_err++; $display("FAIL ill_state: got %b expected 111", st); end
        clr = 1'b1; tick(); clr = 1'b0; m_err = 1'b0;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ill_clear: got %b expected 0", err); end
        // clear coinciding with a fresh illegal transition: set wins
        a = 1'b0; b = 1'b0;
        model_move(2'b00);
        repeat (STEP_LAT - 1) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL ill_set_wins: got %b expected 1", err); end
        repeat (3) tick();
        clr = 1'b1; tick(); clr = 1'b0; m_err = 1'b0;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ill_clear2: got %b expected 0", err); end
    endtask

    task automatic test_enable();
        int total;
        logic [1:0] nab;
        nab = fwd_seq[(idx_of(m_ab) + 3) % 4];
        model_move(nab);
        drive_phase(nab, 10);
        n_vec++; if (up_down !== 1'b0) begin n_err++; $display("FAIL en_pre_dir: got %b expected 0", up_down); end
        en = 1'b0; m_en = 1'b0;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            nab = fwd_seq[(idx_of(m_ab) + 1) % 4];
            model_move(nab);
            drive_phase(nab, 10);
            total += obs_steps + obs_tc_cnt;
        end
        n_vec++; if (total != 0) begin n_err++; $display("FAIL en_off_pulses: got %0d expected 0", total); end
        n_vec++; if (pos !== W'(m_pos)) begin n_err++; $display("FAIL en_off_pos: got %0d expected %0d", pos, m_pos); end
        n_vec++; if (up_down !== m_dir) begin n_err++; $display("FAIL en_off_dir: got %b expected %b", up_down, m_dir); end
        en = 1'b1; m_en = 1'b1;
        drive_phase(m_ab, 5);
        n_vec++; if (obs_steps != 0) begin n_err++; $display("FAIL en_spurious: got %0d expected 0", obs_steps); end
        nab = fwd_seq[(idx_of(m_ab) + 1) % 4];
        model_move(nab);
        drive_phase(nab, 10);
        n_vec++; if (obs_steps != 1) begin n_err++; $display("FAIL en_on_steps: got %0d expected 1", obs_steps); end
        n_vec++; if (pos !== W'(m_pos)) begin n_err++; $display("FAIL en_on_pos: got %0d expected %0d", pos, m_pos); end
    endtask

    task automatic test_zero();
        logic [1:0] back;
        logic [1:0] fwd;
        zero = 1'b1; tick(); zero = 1'b0; m_pos = 0;
        n_vec++; if (pos !== W'(0)) begin n_err++; $display("FAIL zero_clear: got %0d expected 0", pos); end
        fwd  = m_ab;
        back = fwd_seq[(idx_of(m_ab) + 3) % 4];
        model_move(back);
        drive_phase(back, 10);
        n_vec++; if (pos !== W'(PM - 1)) begin n_err++; $display("FAIL zero_pre_pos: got %0d expected %0d", pos, PM - 1); end
        n_vec++; if (obs_tc_cnt != 1) begin n_err++; $display("FAIL zero_pre_tc: got %0d expected 1", obs_tc_cnt); end
        // step up from POS_MAX-1 coinciding with iZERO: zero wins, no wrap
        a = fwd[1]; b = fwd[0];
        model_move(fwd);
        m_pos = 0;
        repeat (STEP_LAT - 1) tick();
        zero = 1'b1; tick(); zero = 1'b0;
        n_vec++; if (step !== 1'b1) begin n_err++; $display("FAIL zero_step: got %b expected 1", step); end
        n_vec++; if (pos !== W'(0)) begin n_err++; $display("FAIL zero_pos: got %0d expected 0", pos); end
        n_vec++; if (tc !== 1'b0) begin n_err++; $display("FAIL zero_tc: got %b expected 0", tc); end
        n_vec++; if (up_down !== 1'b1) begin n_err++; $display("FAIL zero_dir: got %b expected 1", up_down); end
        repeat (5) tick();
    endtask

    task automatic test_random();
        int r, d, g;
        int total;
        logic [1:0] nab;
        for (int i = 0; i < 40; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            m_en = en;
            if ($urandom_range(0, 3) == 0) begin
                g = $urandom_range(1, FL - 1);
                drive_phase(m_ab ^ (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01), g);
                total = obs_steps;
                drive_phase(m_ab, 3);
                total += obs_steps;
                n_vec++; if (total != 0) begin n_err++; $display("FAIL rnd_glitch[%0d]: got %0d steps expected 0", i, total); end
            end
            r = $urandom_range(0, 9);
            if (r < 4)       d = 1;
            else if (r < 8)  d = 3;
            else if (r == 8) d = 2;
            else             d = 0;
            nab = fwd_seq[(idx_of(m_ab) + d) % 4];
            model_move(nab);
            drive_phase(nab, $urandom_range(8, 14));
            n_vec++; if (obs_steps != exp_steps()) begin n_err++; $display("FAIL rnd_steps[%0d]: got %0d expected %0d", i, obs_steps, exp_steps()); end
            n_vec++; if (pos !== W'(m_pos)) begin n_err++; $display("FAIL rnd_pos[%0d]: got %0d expected %0d", i, pos, m_pos); end
            n_vec++; if (up_down !== m_dir) begin n_err++; $display("FAIL rnd_dir[%0d]: got %b expected %b", i, up_down, m_dir); end
            n_vec++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, err, m_err); end
            n_vec++; if (obs_tc_cnt != int'(e_tc)) begin n_err++; $display("FAIL rnd_tc[%0d]: got %0d expected %0d", i, obs_tc_cnt, e_tc); end
            if (m_err) begin
                clr = 1'b1; tick(); clr = 1'b0; m_err = 1'b0;
            end
        end
        en = 1'b1; m_en = 1'b1;
    endtask

    task automatic test_async_reset();
        logic [1:0] nab;
        int steps_seen;
        nab = fwd_seq[(idx_of(m_ab) + 3) % 4];
        model_move(nab);
        drive_phase(nab, 10);
        nab = fwd_seq[(idx_of(m_ab) + 2) % 4];
        model_move(nab);
        drive_phase(nab, 10);
        n_vec++; if (err !== 1'b1 || up_down !== 1'b0) begin n_err++; $display("FAIL arst_pre: got err=%b dir=%b expected err=1 dir=0", err, up_down); end
        nab = fwd_seq[(idx_of(m_ab) + 1) % 4];
        a = nab[1]; b = nab[0];
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        n_vec++; if (step !== 1'b0 || up_down !== 1'b1 || pos !== W'(0) || tc !== 1'b0 || err !== 1'b0 || st !== 3'b000) begin
            n_err++;
            $display("FAIL arst_outputs: got step=%b dir=%b pos=%0d tc=%b err=%b st=%b expected 0 1 0 0 0 000", step, up_down, pos, tc, err, st);
        end
        tick();
        rst = 1'b0;
        steps_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step === 1'b1) steps_seen++;
        end
        n_vec++; if (steps_seen != 0) begin n_err++; $display("FAIL arst_no_step: got %0d expected 0", steps_seen); end
        n_vec++; if (st !== {1'b1, nab}) begin n_err++; $display("FAIL arst_settle: got %b expected %b", st, {1'b1, nab}); end
        n_vec++; if (pos !== W'(0)) begin n_err++; $display("FAIL arst_pos: got %0d expected 0", pos); end
    endtask

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // sequence and final report
    initial begin
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_glitch();
        test_illegal();
        test_enable();
        test_zero();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
